voice_mixer: RTL

Downstream stage of the per-voice NCOs. Takes the 8-bit velocity-scaled sample registers of all voices, sums the enabled voices sequentially (one voice per clock-enabled cycle), scales and saturates the sum to 8 bits, and drives a 1-bit PWM DAC output. A single `MIX_START` strobe per sample period starts each mix. The strobe is issued by the sample-rate sequencer one cycle after it pulses the NCOs' `TRIG_SAMPLE`.

---
 rtl/voice_mixer.sv | 113 +++++++++++
 1 files changed

// File: rtl/voice_mixer.sv
// Sequential voice mixer: sums the enabled voice samples one per CE cycle,
// scales and saturates the sum to 8 bits, and drives a 1-bit PWM DAC.
module voice_mixer #(
    parameter int unsigned VOICES     = 4,
    parameter int unsigned GAIN_SHIFT = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CE,
    input  logic                  MIX_START,
    input  logic [8*VOICES-1:0]   SAMPLES_IN,
    input  logic [VOICES-1:0]     VOICE_EN,
    input  logic                  FLAG_CLR,
    output logic                  MIX_BUSY,
    output logic [7:0]            MIX_OUT,
    output logic                  MIX_VALID,
    output logic                  CLIP,
    output logic                  OVERRUN,
    output logic                  PWM_OUT
);

    localparam int unsigned IDX_W = $clog2(VOICES);
    localparam int unsigned ACC_W = 8 + IDX_W;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         snap_sample [VOICES];
    logic [VOICES-1:0]  snap_en;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   scaled;
    logic [IDX_W-1:0]   idx;
    logic               last_voice;
    logic               sat;
    logic [7:0]         pwm_cnt;
    logic [7:0]         duty;

    assign MIX_BUSY = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        last_voice = (idx == IDX_W'(VOICES - 1));
        addend     = snap_en[idx] ? ACC_W'(snap_sample[idx]) : '0;
        scaled     = acc >> GAIN_SHIFT;
        sat        = (scaled > ACC_W'(255));
        case (state)
            IDLE:    if (MIX_START) state_nxt = ACC;
            ACC:     if (last_voice) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else if (CE) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < VOICES; i++) snap_sample[i] <= '0;
            snap_en   <= '0;
            acc       <= '0;
            idx       <= '0;
            MIX_OUT   <= '0;
            MIX_VALID <= 1'b0;
            CLIP      <= 1'b0;
            OVERRUN   <= 1'b0;
            pwm_cnt   <= '0;
            duty      <= '0;
            PWM_OUT   <= 1'b0;
        end else if (CE) begin
            MIX_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (MIX_START) begin
                        for (int unsigned i = 0; i < VOICES; i++)
                            snap_sample[i] <= SAMPLES_IN[8*i +: 8];
                        snap_en <= VOICE_EN;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    MIX_OUT   <= sat ? '1 : scaled[7:0];
                    MIX_VALID <= 1'b1;
                end
                default: ;
            endcase

            // Set beats clear when both happen on the same edge.
            if ((state == DONE) && sat) CLIP <= 1'b1;
            else if (FLAG_CLR)          CLIP <= 1'b0;

            if (MIX_START && (state != IDLE)) OVERRUN <= 1'b1;
            else if (FLAG_CLR)                OVERRUN <= 1'b0;

            // Duty only reloads at the wrap so a period never changes mid-way.
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) duty <= MIX_OUT;
            PWM_OUT <= (pwm_cnt < duty);
        end
    end

endmodule
